// File: rtl/axi4_arbiter_w.sv
// rtl/axi4_arbiter_w.sv - two-master AXI4 write-channel (AW/W/B) arbiter
//
// Purpose:
//   Shares one slave write port between masters s0 and s1. A master owns the
//   port for a complete write: AW handshake, every W beat up to WLAST, then the
//   B handshake. Only a one-hot grant is produced; the fabric's AW/W/B muxes
//   steer on m_WGRNT. Round-robin between the masters, s0 first after reset.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s0_AWVALID/WVALID/WLAST/BREADY   master0 write-channel handshake inputs
//   s1_AWVALID/WVALID/WLAST/BREADY   master1 write-channel handshake inputs
//   m_AWREADY/WREADY/BVALID          slave write-channel handshake inputs
//   m_WGRNT   [1:0]       grant {s1,s0}, one-hot or 2'b00
//   m_WBUSY               1 while a write is owned (state != IDLE)
//
// Configuration:
//   AXI4_ARB_W_PARK_EN    when defined, the grant parks on the last owner in
//                         IDLE and that master may restart with zero latency.

module axi4_arbiter_w (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s0_AWVALID,
    input  logic       s0_WVALID,
    input  logic       s0_WLAST,
    input  logic       s0_BREADY,
    input  logic       s1_AWVALID,
    input  logic       s1_WVALID,
    input  logic       s1_WLAST,
    input  logic       s1_BREADY,
    input  logic       m_AWREADY,
    input  logic       m_WREADY,
    input  logic       m_BVALID,
    output logic [1:0] m_WGRNT,
    output logic       m_WBUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;      // 0 = s0, 1 = s1
    logic   rr_ptr_q, rr_ptr_d;    // master that wins a simultaneous request
    logic   w_done_q, w_done_d;    // last W beat already accepted ahead of AW

    logic   own_awvalid;
    logic   own_wvalid;
    logic   own_wlast;
    logic   own_bready;
    logic   aw_hs;
    logic   wl_hs;
    logic   b_hs;
    logic   any_req;
    logic   arb_pick;

    // Handshakes are qualified with the current owner's signals only; the
    // other master's channel is not steered to the slave and must be ignored.
    assign own_awvalid = owner_q ? s1_AWVALID : s0_AWVALID;
    assign own_wvalid  = owner_q ? s1_WVALID  : s0_WVALID;
    assign own_wlast   = owner_q ? s1_WLAST   : s0_WLAST;
    assign own_bready  = owner_q ? s1_BREADY  : s0_BREADY;

    assign aw_hs = own_awvalid & m_AWREADY;
    assign wl_hs = own_wvalid & own_wlast & m_WREADY;
    assign b_hs  = m_BVALID & own_bready;

    assign any_req  = s0_AWVALID | s1_AWVALID;
    // Sole requester wins outright; a tie goes to the round-robin pointer.
    assign arb_pick = (s0_AWVALID & s1_AWVALID) ? rr_ptr_q : s1_AWVALID;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            w_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            w_done_q <= w_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        w_done_d = w_done_q;

        case (state_q)
            IDLE: begin
`ifdef AXI4_ARB_W_PARK_EN
                // The parked master already sees the slave, so an AW accepted
                // here is real and skips ADDR entirely.
                if (aw_hs) begin
                    state_d = wl_hs ? RESP : DATA;
                end else if (any_req) begin
                    state_d = ADDR;
                    owner_d = arb_pick;
                end
`else
                if (any_req) begin
                    state_d = ADDR;
                    owner_d = arb_pick;
                end
`endif
            end

            ADDR: begin
                // W may lead AW; remember a completed burst so the response
                // phase follows straight after the address handshake.
                if (wl_hs) begin
                    w_done_d = 1'b1;
                end
                if (aw_hs) begin
                    state_d = (w_done_q | wl_hs) ? RESP : DATA;
                end
            end

            DATA: begin
                if (wl_hs) begin
                    state_d = RESP;
                end
            end

            RESP: begin
                if (b_hs) begin
                    state_d  = IDLE;
                    rr_ptr_d = ~owner_q;
                    w_done_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        m_WGRNT = 2'b00;
        m_WBUSY = 1'b0;
        if (state_q != IDLE) begin
            m_WGRNT = {owner_q, ~owner_q};
            m_WBUSY = 1'b1;
        end else begin
`ifdef AXI4_ARB_W_PARK_EN
            m_WGRNT = {owner_q, ~owner_q};
`else
            m_WGRNT = 2'b00;
`endif
        end
    end

    // Grant must never select both masters.
    grant_onehot_a : assert property (@(posedge clk) disable iff (!rst_n)
        m_WGRNT != 2'b11);

endmodule

// File: tb/tb_axi4_arbiter_w.sv
// tb/tb_axi4_arbiter_w.sv - scoreboard bench for axi4_arbiter_w
module tb_axi4_arbiter_w;

    logic       clk;
    logic       rst_n;
    logic       s0_awvalid, s0_wvalid, s0_wlast, s0_bready;
    logic       s1_awvalid, s1_wvalid, s1_wlast, s1_bready;
    logic       m_awready, m_wready, m_bvalid;
    logic [1:0] m_wgrnt;
    logic       m_wbusy;

    int checks   = 0;
    int failures = 0;

    // Expected {grant[1:0], busy} after each clock edge.
    logic [2:0] exp_q [$];

    axi4_arbiter_w dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s0_AWVALID (s0_awvalid),
        .s0_WVALID  (s0_wvalid),
        .s0_WLAST   (s0_wlast),
        .s0_BREADY  (s0_bready),
        .s1_AWVALID (s1_awvalid),
        .s1_WVALID  (s1_wvalid),
        .s1_WLAST   (s1_wlast),
        .s1_BREADY  (s1_bready),
        .m_AWREADY  (m_awready),
        .m_WREADY   (m_wready),
        .m_BVALID   (m_bvalid),
        .m_WGRNT    (m_wgrnt),
        .m_WBUSY    (m_wbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus word: [10:7] s0 {aw,w,wl,b}  [6:3] s1 {aw,w,wl,b}  [2:0] {awr,wr,bv}
    task automatic drive(input logic [10:0] v);
        {s0_awvalid, s0_wvalid, s0_wlast, s0_bready,
         s1_awvalid, s1_wvalid, s1_wlast, s1_bready,
         m_awready, m_wready, m_bvalid} = v;
    endtask

    task automatic do_reset();
        drive(11'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] e;
        drive(11'b1110_1110_111);
        rst_n = 1'b0;
        #1;
        exp_q.push_back(3'b000);
        e = exp_q.pop_front();
        checks++;
        if ({m_wgrnt, m_wbusy} !== e) begin
            failures++;
            $display("FAIL reset_async got=%b want=%b", {m_wgrnt, m_wbusy}, e);
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(3'b000);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({m_wgrnt, m_wbusy} !== e) begin
                failures++;
                $display("FAIL reset_hold[%0d] got=%b want=%b", i, {m_wgrnt, m_wbusy}, e);
            end
        end
        drive(11'b0);
        rst_n = 1'b1;
        exp_q.push_back(3'b000);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({m_wgrnt, m_wbusy} !== e) begin
            failures++;
            $display("FAIL reset_idle got=%b want=%b", {m_wgrnt, m_wbusy}, e);
        end
    endtask

    task automatic test_single_write();
        logic [10:0] st [11] = '{
            11'b1000_0000_000, 11'b1000_0000_000, 11'b1000_0000_100,
            11'b0100_0000_010, 11'b0101_0000_011, 11'b0100_0000_010,
            11'b0110_0000_000, 11'b0110_0000_010, 11'b0000_0000_001,
            11'b0001_0000_001, 11'b0000_0000_000};
        logic [2:0] ex [11] = '{
            3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011,
            3'b011, 3'b011, 3'b011, 3'b000, 3'b000};
        logic [2:0] e;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({m_wgrnt, m_wbusy} !== e) begin
                failures++;
                $display("FAIL single_write[%0d] got=%b want=%b", i, {m_wgrnt, m_wbusy}, e);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [10:0] st [9] = '{
            11'b1000_1000_000, 11'b1110_1000_110, 11'b0001_1000_001,
            11'b1000_1000_000, 11'b1000_1110_110, 11'b1000_1001_001,
            11'b1000_1000_000, 11'b1110_1000_110, 11'b0001_0000_001};
        logic [2:0] ex [9] = '{
            3'b011, 3'b011, 3'b000, 3'b101, 3'b101, 3'b000,
            3'b011, 3'b011, 3'b000};
        logic [2:0] e;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({m_wgrnt, m_wbusy} !== e) begin
                failures++;
                $display("FAIL round_robin[%0d] got=%b want=%b", i, {m_wgrnt, m_wbusy}, e);
            end
        end
    endtask

    task automatic test_w_before_aw();
        logic [10:0] st [6] = '{
            11'b0000_1000_000, 11'b0000_1110_010, 11'b0000_1000_000,
            11'b0000_1000_000, 11'b0000_1000_100, 11'b0000_0001_001};
        logic [2:0] ex [6] = '{
            3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b000};
        logic [2:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({m_wgrnt, m_wbusy} !== e) begin
                failures++;
                $display("FAIL w_before_aw[%0d] got=%b want=%b", i, {m_wgrnt, m_wbusy}, e);
            end
        end
    endtask

    task automatic test_no_preempt();
        logic [10:0] st [9] = '{
            11'b1000_1000_000, 11'b1000_1110_110, 11'b0101_1000_011,
            11'b0110_1000_010, 11'b0000_1001_001, 11'b0001_1000_001,
            11'b0000_1000_000, 11'b0000_1110_110, 11'b0000_0001_001};
        logic [2:0] ex [9] = '{
            3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b000,
            3'b101, 3'b101, 3'b000};
        logic [2:0] e;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({m_wgrnt, m_wbusy} !== e) begin
                failures++;
                $display("FAIL no_preempt[%0d] got=%b want=%b", i, {m_wgrnt, m_wbusy}, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] st [9] = '{
            11'b1000_0000_000, 11'b1110_0000_110, 11'b0001_0000_001,
            11'b0000_1000_000, 11'b0000_1000_100,
            11'b1000_1000_000, 11'b1110_1000_110, 11'b0001_1000_001,
            11'b0000_1000_000};
        logic [2:0] ex [9] = '{
            3'b011, 3'b011, 3'b000, 3'b101, 3'b101,
            3'b011, 3'b011, 3'b000, 3'b101};
        logic [2:0] e;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 5) begin
                // Owner s1 is in DATA; abort it asynchronously mid-cycle.
                drive(11'b0000_1100_010);
                #2;
                rst_n = 1'b0;
                #1;
                exp_q.push_back(3'b000);
                e = exp_q.pop_front();
                checks++;
                if ({m_wgrnt, m_wbusy} !== e) begin
                    failures++;
                    $display("FAIL reset_mid_async got=%b want=%b", {m_wgrnt, m_wbusy}, e);
                end
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({m_wgrnt, m_wbusy} !== e) begin
                failures++;
                $display("FAIL reset_mid[%0d] got=%b want=%b", i, {m_wgrnt, m_wbusy}, e);
            end
        end
    endtask

`ifdef AXI4_ARB_W_PARK_EN
    task automatic test_park();
        logic [10:0] st [7] = '{
            11'b0000_1000_000, 11'b0000_1110_110, 11'b0000_0001_001,
            11'b0000_1000_100, 11'b0000_1110_010, 11'b0000_0001_001,
            11'b1000_0000_000};
        logic [2:0] ex [7] = '{
            3'b101, 3'b101, 3'b100, 3'b101, 3'b101, 3'b100, 3'b011};
        logic [2:0] e;
        do_reset();
        exp_q.push_back(3'b010);
        e = exp_q.pop_front();
        checks++;
        if ({m_wgrnt, m_wbusy} !== e) begin
            failures++;
            $display("FAIL park_reset got=%b want=%b", {m_wgrnt, m_wbusy}, e);
        end
        for (int i = 0; i < 7; i++) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({m_wgrnt, m_wbusy} !== e) begin
                failures++;
                $display("FAIL park[%0d] got=%b want=%b", i, {m_wgrnt, m_wbusy}, e);
            end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        drive(11'b0);
        @(posedge clk); #1;
`ifdef AXI4_ARB_W_PARK_EN
        test_park();
`else
        test_reset();
        test_single_write();
        test_round_robin();
        test_w_before_aw();
        test_no_preempt();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
